mult_job_sequencer: RTL and testbench

Initiator-side sequencer for the 4-bit multiplier. It reads operand pairs from an operand RAM, presents them to the multiplier datapath, and drives `strt_cmpt` into the multiplier RAM controller. It waits for the controller to reach ST_END, writes the product to a result RAM, and releases the start handshake. It then steps to the next job until the batch is complete.

---
 rtl/mult_job_sequencer.sv | 144 ++++++++++++++
 tb/tb_mult_job_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_job_sequencer.sv
// Initiator-side job sequencer for the 4-bit multiplier: fetches operand
// pairs, handshakes strt_cmpt with the RAM controller and stores products.
module mult_job_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] op_addr_o,
    input  logic [7:0]        op_data_i,
    output logic [3:0]        a_o,
    output logic [3:0]        b_o,
    output logic              strt_cmpt_o,
    input  logic [2:0]        ctrl_state_i,
    input  logic [7:0]        product_i,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic [7:0]        res_data_o,
    output logic              res_we_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_END  = 3'd5;
    localparam int         WD_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_WRITE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [WD_W-1:0]   wd;
    logic              wd_hit;

    assign op_addr_o = idx;
    assign wd_hit    = (wd == WD_W'(TIMEOUT - 1));

    // Outputs are set on the transition into the state that owns them,
    // so they behave as Moore outputs of the registered state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            idx         <= '0;
            last_idx    <= '0;
            wd          <= '0;
            a_o         <= '0;
            b_o         <= '0;
            res_addr_o  <= '0;
            res_data_o  <= '0;
            strt_cmpt_o <= 1'b0;
            res_we_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            res_we_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go_i) begin
                        error_o <= 1'b0;
                        idx     <= '0;
                        busy_o  <= 1'b1;
                        if (len_i == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            last_idx <= ADDR_W'(len_i - 1'b1);
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    a_o         <= op_data_i[7:4];
                    b_o         <= op_data_i[3:0];
                    wd          <= '0;
                    strt_cmpt_o <= 1'b1;
                    state       <= S_START;
                end
                S_START: begin
                    if (ctrl_state_i == ST_END) begin
                        strt_cmpt_o <= 1'b0;
                        res_we_o    <= 1'b1;
                        res_addr_o  <= idx;
                        res_data_o  <= product_i;
                        state       <= S_WRITE;
                    end else if (wd_hit) begin
                        strt_cmpt_o <= 1'b0;
                        error_o     <= 1'b1;
                        done_o      <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_WRITE: begin
                    wd    <= '0;
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (ctrl_state_i == ST_IDLE) begin
                        if (idx == last_idx) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end else if (wd_hit) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    strt_cmpt_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural RAM controller,
// operand RAM and multiplier datapath around it.
module tb_mult_job_sequencer;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              go = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [ADDR_W-1:0] op_addr;
    logic [7:0]        op_data = '0;
    logic [3:0]        a;
    logic [3:0]        b;
    logic              strt;
    logic [2:0]        cst = 3'd0;
    logic [7:0]        product;
    logic [ADDR_W-1:0] res_addr;
    logic [7:0]        res_data;
    logic              res_we;
    logic              busy;
    logic              done;
    logic              error;

    logic [7:0] ram [16];
    bit         stuck = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    typedef struct {
        int c;
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  done_cnt = 0;
    int  done_at = -1;
    int  strt_cnt = 0;

    mult_job_sequencer #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .go_i        (go),
        .len_i       (len),
        .op_addr_o   (op_addr),
        .op_data_i   (op_data),
        .a_o         (a),
        .b_o         (b),
        .strt_cmpt_o (strt),
        .ctrl_state_i(cst),
        .product_i   (product),
        .res_addr_o  (res_addr),
        .res_data_o  (res_data),
        .res_we_o    (res_we),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) op_data <= ram[op_addr];

    assign product = 8'(a) * 8'(b);

    // Controller: IDLE -> BIT0..BIT3 -> END, back to IDLE once strt drops
    always @(posedge clk or negedge rst) begin
        if (!rst) cst <= 3'd0;
        else if (stuck) cst <= 3'd3;
        else begin
            case (cst)
                3'd0: if (strt) cst <= 3'd1;
                3'd1, 3'd2, 3'd3, 3'd4: cst <= cst + 3'd1;
                3'd5: if (!strt) cst <= 3'd0;
                default: cst <= 3'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (res_we) wq.push_back('{cyc - t0, int'(res_addr), int'(res_data)});
        if (done) begin
            done_cnt++;
            done_at = cyc - t0;
        end
        if (strt) strt_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wq.delete();
        done_cnt = 0;
        done_at  = -1;
        strt_cnt = 0;
    endtask

    task automatic start(input int n);
        @(negedge clk);
        t0  = cyc;
        go  = 1'b1;
        len = (ADDR_W + 1)'(n);
        @(negedge clk);
        go  = 1'b0;
        len = '0;
        chk("busy_c1", busy, 1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            if (done_cnt != 0) break;
            @(negedge clk);
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic batch4(input bit poke);
        int exp_d[4];
        exp_d = '{225, 0, 14, 9};
        clear_log();
        start(4);
        if (poke) begin
            repeat (13) @(negedge clk);
            go  = 1'b1;
            len = 5'd2;
            @(negedge clk);
            go  = 1'b0;
            len = '0;
        end
        wait_done();
        chk("b_nwr", wq.size(), 4);
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            chk("b_addr", wq[k].addr, k);
            chk("b_data", wq[k].data, exp_d[k]);
            chk("b_cyc", wq[k].c, 9 + 10 * k);
        end
        chk("b_done_at", done_at, 41);
        chk("b_done_cnt", done_cnt, 1);
        chk("b_strt", strt_cnt, 24);
        chk("b_err", error, 0);
        chk("b_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        foreach (ram[i]) ram[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_strt", strt, 0);
        chk("rst_we", res_we, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_ab", {a, b}, 0);
        chk("rst_res", {res_addr, res_data}, 0);
        chk("rst_opaddr", op_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        // single job
        ram[0] = 8'h35;
        clear_log();
        start(1);
        wait_done();
        chk("s_nwr", wq.size(), 1);
        if (wq.size() > 0) begin
            chk("s_addr", wq[0].addr, 0);
            chk("s_data", wq[0].data, 15);
            chk("s_cyc", wq[0].c, 9);
        end
        chk("s_done_at", done_at, 11);
        chk("s_strt", strt_cnt, 6);
        chk("s_err", error, 0);
        chk("s_a", a, 3);
        chk("s_b", b, 5);

        // zero length
        clear_log();
        start(0);
        wait_done();
        chk("z_done_at", done_at, 1);
        chk("z_nwr", wq.size(), 0);
        chk("z_strt", strt_cnt, 0);

        // stuck controller
        stuck = 1'b1;
        clear_log();
        start(1);
        wait_done();
        chk("t_done_at", done_at, 19);
        chk("t_strt", strt_cnt, 16);
        chk("t_nwr", wq.size(), 0);
        chk("t_err", error, 1);
        chk("t_strt_low", strt, 0);
        stuck = 1'b0;
        repeat (5) @(negedge clk);
        chk("t_sticky", error, 1);
        clear_log();
        start(1);
        chk("t_err_clr", error, 0);
        wait_done();
        chk("t2_done_at", done_at, 11);
        chk("t2_nwr", wq.size(), 1);
        if (wq.size() > 0) chk("t2_data", wq[0].data, 15);

        // batch, then batch with ignored go pulse
        ram[0] = 8'hFF;
        ram[1] = 8'h00;
        ram[2] = 8'h27;
        ram[3] = 8'h91;
        batch4(1'b0);
        batch4(1'b1);

        // reset during job 2 S_START
        clear_log();
        start(4);
        repeat (14) @(negedge clk);
        chk("r_pre_strt", strt, 1);
        chk("r_pre_addr", op_addr, 1);
        rst = 1'b0;
        #1;
        chk("r_strt", strt, 0);
        chk("r_busy", busy, 0);
        chk("r_opaddr", op_addr, 0);
        chk("r_res", {res_addr, res_data}, 0);
        chk("r_ab", {a, b}, 0);
        chk("r_nwr", wq.size(), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_log();
        start(2);
        wait_done();
        chk("r2_nwr", wq.size(), 2);
        if (wq.size() > 1) begin
            chk("r2_addr0", wq[0].addr, 0);
            chk("r2_data0", wq[0].data, 225);
            chk("r2_addr1", wq[1].addr, 1);
            chk("r2_data1", wq[1].data, 0);
        end
        chk("r2_done_at", done_at, 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
